// File: rtl/cam_gen_pkg.sv
// Shared types for the camera timing generator: pattern modes, FSM states
// and the RGB444 two-byte packing used on the pixel bus.
package cam_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID       = 2'd0,
        MODE_LINE_TOGGLE = 2'd1,
        MODE_BARS        = 2'd2,
        MODE_GRADIENT    = 2'd3
    } cam_mode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } cam_state_e;

    // Even column carries the red nibble, odd column carries green/blue.
    function automatic logic [7:0] pack_rgb444(input logic [11:0] pix, input logic odd_byte);
        return odd_byte ? pix[7:0] : {4'h0, pix[11:8]};
    endfunction

endpackage

// File: rtl/cam_stream_gen_if.sv
// OV7670-style parallel camera bus: pixel clock, frame/line syncs and data byte.
interface cam_stream_gen_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] px_data;

    modport master (output pclk, vsync, href, px_data);
    modport slave  (input  pclk, vsync, href, px_data);
endinterface

// File: rtl/cam_pclk_div.sv
// Divides clk down to pclk (DIV clk cycles per period) and flags the clk
// edges on which pclk rises or falls.
module cam_pclk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt;
    logic             at_half;

    assign at_half  = (cnt == CNT_LAST);
    assign rise_stb = at_half & ~pclk;
    assign fall_stb = at_half &  pclk;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            pclk <= 1'b0;
        end else if (at_half) begin
            cnt  <= '0;
            pclk <= ~pclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cam_stream_gen.sv
// Camera timing/test-pattern generator. Define CAMGEN_FRAME_CNT_EN to keep a
// 16-bit completed-frame counter that also animates the GRADIENT pattern.
module cam_stream_gen
    import cam_gen_pkg::*;
#(
    parameter int          IMG_W       = 160,
    parameter int          IMG_H       = 120,
    parameter int          H_BLANK     = 4,
    parameter int          V_BLANK     = 4,
    parameter int          VSYNC_LINES = 2,
    parameter int          PCLK_DIV    = 4,
    parameter logic [11:0] SOLID_COLOR = 12'h00F
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [1:0]              mode,
    cam_stream_gen_if.master        cam,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt
);

    localparam int LINE_SLOTS  = IMG_W * 2 + H_BLANK;
    localparam int FRAME_LINES = IMG_H + V_BLANK;
    localparam int COL_W       = $clog2(LINE_SLOTS);
    localparam int LINE_W      = $clog2(FRAME_LINES);
    localparam int X_W         = COL_W - 1;
    localparam int BAR_W       = IMG_W / 8;

    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(LINE_SLOTS - 1);
    localparam logic [COL_W-1:0]  ACTIVE_COLS = COL_W'(IMG_W * 2);
    localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(FRAME_LINES - 1);
    localparam logic [LINE_W-1:0] VS_LINES    = LINE_W'(VSYNC_LINES);
    localparam logic [LINE_W-1:0] VB_LINES    = LINE_W'(V_BLANK);
    localparam logic [X_W-1:0]    BAR_DIV     = X_W'(BAR_W);

    logic fall_stb;
    logic rise_stb_unused;

    cam_pclk_div #(.DIV(PCLK_DIV)) u_div (
        .clk      (clk),
        .rst      (rst),
        .pclk     (cam.pclk),
        .rise_stb (rise_stb_unused),
        .fall_stb (fall_stb)
    );

    cam_state_e        state, state_nxt;
    cam_mode_e         mode_q, mode_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic [LINE_W-1:0] line, line_nxt;
    logic              end_of_frame;
    logic              frame_done_q;
    logic [11:0]       fc_term;

    assign end_of_frame = (state == S_FRAME) && (col == LAST_COL) && (line == LAST_LINE);

`ifdef CAMGEN_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_nxt;

    assign frame_cnt_nxt = frame_cnt_q + 16'(end_of_frame);
    assign frame_cnt     = frame_cnt_q;
    assign fc_term       = frame_cnt_nxt[11:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           frame_cnt_q <= '0;
        else if (fall_stb) frame_cnt_q <= frame_cnt_nxt;
    end
`else
    assign frame_cnt = '0;
    assign fc_term   = '0;
`endif

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        line_nxt  = line;
        mode_nxt  = mode_q;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_FRAME;
                    col_nxt   = '0;
                    line_nxt  = '0;
                    mode_nxt  = cam_mode_e'(mode);
                end
            end
            S_FRAME: begin
                if (col == LAST_COL) begin
                    col_nxt = '0;
                    if (line == LAST_LINE) begin
                        line_nxt = '0;
                        if (enable) mode_nxt  = cam_mode_e'(mode);
                        else        state_nxt = S_IDLE;
                    end else begin
                        line_nxt = line + 1'b1;
                    end
                end else begin
                    col_nxt = col + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed for the slot about to start so they register on the same fall strobe.
    logic              in_frame_nxt, vsync_nxt, href_nxt;
    logic [X_W-1:0]    px_x;
    logic [LINE_W-1:0] px_y;
    logic [2:0]        bar;
    logic [11:0]       pix;
    logic [7:0]        px_nxt;

    assign in_frame_nxt = (state_nxt == S_FRAME);
    assign vsync_nxt    = in_frame_nxt && (line_nxt < VS_LINES);
    assign href_nxt     = in_frame_nxt && (line_nxt >= VB_LINES) && (col_nxt < ACTIVE_COLS);
    assign px_x         = col_nxt[COL_W-1:1];
    assign px_y         = line_nxt - VB_LINES;
    assign bar          = 3'(px_x / BAR_DIV);

    always_comb begin
        pix = SOLID_COLOR;
        case (mode_nxt)
            MODE_SOLID:       pix = SOLID_COLOR;
            MODE_LINE_TOGGLE: pix = px_y[0] ? ~SOLID_COLOR : SOLID_COLOR;
            MODE_BARS:        pix = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
            MODE_GRADIENT:    pix = 12'(px_x) + 12'(px_y) + fc_term;
            default:          pix = SOLID_COLOR;
        endcase
        px_nxt = href_nxt ? pack_rgb444(pix, col_nxt[0]) : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            mode_q       <= MODE_SOLID;
            col          <= '0;
            line         <= '0;
            cam.vsync    <= 1'b0;
            cam.href     <= 1'b0;
            cam.px_data  <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= fall_stb && end_of_frame;
            if (fall_stb) begin
                state       <= state_nxt;
                mode_q      <= mode_nxt;
                col         <= col_nxt;
                line        <= line_nxt;
                cam.vsync   <= vsync_nxt;
                cam.href    <= href_nxt;
                cam.px_data <= px_nxt;
            end
        end
    end

    assign busy       = (state == S_FRAME);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Self-checking bench for cam_stream_gen on a reduced frame geometry, with a
// slot-indexed reference model of the camera timing and test patterns.
module tb_cam_stream_gen;

    localparam int          IMG_W       = 16;
    localparam int          IMG_H       = 6;
    localparam int          H_BLANK     = 4;
    localparam int          V_BLANK     = 4;
    localparam int          VSYNC_LINES = 2;
    localparam int          PCLK_DIV    = 4;
    localparam logic [11:0] SOLID_COLOR = 12'h00F;

    localparam int LINE_SLOTS  = IMG_W * 2 + H_BLANK;
    localparam int FRAME_SLOTS = LINE_SLOTS * (IMG_H + V_BLANK);
    localparam int FRAME_CLKS  = FRAME_SLOTS * PCLK_DIV;
    localparam int BUDGET      = FRAME_CLKS * 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    cam_stream_gen_if cam_bus ();

    cam_stream_gen #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .H_BLANK     (H_BLANK),
        .V_BLANK     (V_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .PCLK_DIV    (PCLK_DIV),
        .SOLID_COLOR (SOLID_COLOR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .cam        (cam_bus.master),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a flat run of slots, decoded with division.
    bit model_on = 1'b0;
    bit m_active = 1'b0;
    int m_slot   = 0;
    int m_mode   = 0;
    int m_fc     = 0;
    int m_done   = 0;
    int fd_seen  = 0;
    int pclk_rises = 0;

    function automatic logic [9:0] exp_bus(input int slot, input int md, input int fc);
        int ln, cl, x, y, b, p, fc_eff;
        logic vs, hr;
        logic [7:0] d;
        ln = slot / LINE_SLOTS;
        cl = slot % LINE_SLOTS;
        vs = (ln < VSYNC_LINES);
        hr = (ln >= V_BLANK) && (cl < IMG_W * 2);
        x  = cl / 2;
        y  = ln - V_BLANK;
`ifdef CAMGEN_FRAME_CNT_EN
        fc_eff = fc % 65536;
`else
        fc_eff = 0;
`endif
        case (md)
            0:       p = int'(SOLID_COLOR);
            1:       p = (y % 2 == 1) ? (int'(SOLID_COLOR) ^ 'hFFF) : int'(SOLID_COLOR);
            2: begin
                b = x / (IMG_W / 8);
                p = (((b & 4) != 0) ? 'hF00 : 0) | (((b & 2) != 0) ? 'h0F0 : 0) | (((b & 1) != 0) ? 'h00F : 0);
            end
            default: p = (x + y + fc_eff) % 4096;
        endcase
        d = (cl % 2 == 0) ? 8'(p >> 8) : 8'(p & 255);
        if (!hr) d = 8'h00;
        return {vs, hr, d};
    endfunction

    function automatic int exp_fc(input int fc);
`ifdef CAMGEN_FRAME_CNT_EN
        return fc % 65536;
`else
        return 0 * fc;
`endif
    endfunction

    always @(negedge cam_bus.pclk) begin
        if (model_on && !rst) begin
            if (m_active) begin
                if (m_slot == FRAME_SLOTS - 1) begin
                    m_done++;
                    m_fc++;
                    if (enable) begin
                        m_slot = 0;
                        m_mode = int'(mode);
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_slot++;
                end
            end else if (enable) begin
                m_active = 1'b1;
                m_slot   = 0;
                m_mode   = int'(mode);
            end
        end
    end

    // Receiver side: compare the bus on every pclk rise.
    always @(posedge cam_bus.pclk) begin
        logic [9:0] e;
        pclk_rises++;
        #1;
        if (model_on && !rst) begin
            e = m_active ? exp_bus(m_slot, m_mode, m_fc) : 10'h000;
            check("vsync",     32'(cam_bus.vsync),   32'(e[9]));
            check("href",      32'(cam_bus.href),    32'(e[8]));
            check("px_data",   32'(cam_bus.px_data), 32'(e[7:0]));
            check("busy",      32'(busy),            32'(m_active));
            check("frame_cnt", 32'(frame_cnt),       32'(exp_fc(m_fc)));
        end
    end

    always @(negedge clk) begin
        if (model_on && !rst && frame_done) fd_seen++;
    end

    task automatic rearm_model();
        m_active = 1'b0;
        m_slot   = 0;
        m_fc     = 0;
        m_done   = 0;
        fd_seen  = 0;
        model_on = 1'b1;
    endtask

    task automatic wait_slot(input int target, input string tag);
        int n = 0;
        while (!(m_active && m_slot == target) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < BUDGET), 32'd1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (m_done < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < BUDGET), 32'd1);
    endtask

    task automatic wait_active(input bit want, input string tag);
        int n = 0;
        while (m_active != want && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < BUDGET), 32'd1);
    endtask

    task automatic run_random(input int n_clk);
        for (int i = 0; i < n_clk; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_pclk"},       32'(cam_bus.pclk),    32'd0);
        check({pfx, "_vsync"},      32'(cam_bus.vsync),   32'd0);
        check({pfx, "_href"},       32'(cam_bus.href),    32'd0);
        check({pfx, "_px_data"},    32'(cam_bus.px_data), 32'd0);
        check({pfx, "_busy"},       32'(busy),            32'd0);
        check({pfx, "_frame_done"}, 32'(frame_done),      32'd0);
        check({pfx, "_frame_cnt"},  32'(frame_cnt),       32'd0);
    endtask

    initial begin
        int done0, rises0;

        rst    = 1'b1;
        enable = 1'b1;
        mode   = 2'd0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");

        // Release: pclk rises after PCLK_DIV/2 edges, falls (and vsync rises) after PCLK_DIV.
        @(negedge clk);
        rst = 1'b0;
        rearm_model();
        @(posedge clk); #1 check("start_pclk_edge1", 32'(cam_bus.pclk), 32'd0);
        @(posedge clk); #1 check("start_pclk_edge2", 32'(cam_bus.pclk), 32'd1);
        @(posedge clk); #1 check("start_pclk_edge3", 32'(cam_bus.pclk), 32'd1);
        @(posedge clk); #1 check("start_pclk_edge4", 32'(cam_bus.pclk), 32'd0);
        check("start_vsync", 32'(cam_bus.vsync), 32'd1);

        // Mode switch 0 -> 3 mid-frame: current frame stays SOLID, next is GRADIENT.
        wait_slot(LINE_SLOTS * (V_BLANK + 1), "wait_mid_frame");
        @(negedge clk);
        mode = 2'd3;
        wait_done(2, "wait_two_frames");

        run_random(FRAME_CLKS * 4);
        #2 check("frame_done_count", 32'(fd_seen), 32'(m_done));

        // Drop enable mid-frame: the frame completes, then the bus idles with pclk running.
        wait_slot(LINE_SLOTS * 3 + 5, "wait_drop_point");
        @(negedge clk);
        enable = 1'b0;
        done0  = fd_seen;
        wait_active(1'b0, "wait_idle");
        repeat (8) @(negedge clk);
        check("drop_frame_done", 32'(fd_seen), 32'(done0 + 1));
        check("idle_busy",    32'(busy),            32'd0);
        check("idle_vsync",   32'(cam_bus.vsync),   32'd0);
        check("idle_href",    32'(cam_bus.href),    32'd0);
        check("idle_px_data", 32'(cam_bus.px_data), 32'd0);
        rises0 = pclk_rises;
        repeat (40) @(negedge clk);
        check("idle_pclk_rises", 32'(pclk_rises - rises0), 32'(40 / PCLK_DIV));

        @(negedge clk);
        enable = 1'b1;
        wait_active(1'b1, "wait_restart");
        run_random(FRAME_CLKS * 2);

        // Asynchronous reset in the middle of an active line.
        wait_slot(LINE_SLOTS * (V_BLANK + 1) + 3, "wait_active_line");
        @(posedge clk);
        #3;
        model_on = 1'b0;
        rst      = 1'b1;
        #1 check_all_zero("mid_reset");

        @(negedge clk);
        mode = 2'd3;
        @(negedge clk);
        rst = 1'b0;
        rearm_model();
        wait_done(2, "wait_after_reset");
        repeat (20) @(negedge clk);
        #2 check("final_frame_done_count", 32'(fd_seen), 32'(m_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
